button_ctrl: RTL and testbench
==============================

Name: button_ctrl

Overview:
- Parametrised, multi-channel successor to the single-channel halt latch.
- Each channel takes a raw board button and runs it through a 2-flop synchroniser and a debounce filter.
- A per-channel runtime-selectable mode then drives the control output: level, toggle, one-shot pulse, or set/clear latch.
- Sits between board push-buttons and core control inputs (Halt, Step, Run, etc.).

Parameters:
- N_CH, 3: number of independent button channels (≥1).
- DEBOUNCE_CYCLES, 16: consecutive stable clocks required to accept a new level (≥1).
- ACTIVE_LOW, 1: 1 = raw button reads 0 when pressed; 0 = raw reads 1 when pressed.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): localparam, debounce counter width.

Ports:
- Clock  in  1  system clock, all state on posedge.
- Reset  in  1  asynchronous, active-low reset.
- ButtonIn  in  N_CH  raw asynchronous button levels.
- Mode  in  2*N_CH  per-channel mode, bits [2i+1:2i] for channel i: 0 LEVEL, 1 TOGGLE, 2 PULSE, 3 LATCH.
- Clear  in  N_CH  synchronous clear of the TOGGLE/LATCH output, per channel.
- Pressed  out  N_CH  debounced pressed level (polarity normalised, 1 = pressed).
- PressEdge  out  N_CH  one-cycle pulse on accepted press.
- Out  out  N_CH  mode-dependent control output.

Behaviour:
- Reset (Reset=0, async):
  - sync flops = released level;
  - counters = 0;
  - Pressed = 0, PressEdge = 0, Out = 0.
  - Reset mid-bounce discards all partial counts.
- Synchroniser: two flops per channel. Polarity normalised after sync: p = ACTIVE_LOW ? ~sync2 : sync2.
- Debounce, per channel:
  - If p == Pressed: counter := 0.
  - Else: counter increments. On the edge where counter would reach DEBOUNCE_CYCLES, Pressed := p and counter := 0.
  - Any return of p to Pressed before then restarts the count. Glitches shorter than DEBOUNCE_CYCLES clocks never change Pressed.
  - Latency from a clean raw change to Pressed change = 2 + DEBOUNCE_CYCLES clock edges.
  - Counter saturates logically; it never wraps.
- Edge: rise = accepted 0→1 transition of Pressed (next-state 1, current 0).
  - PressEdge is registered and high for exactly the one cycle after Pressed rises, i.e. asserted in the same cycle Pressed first reads 1.
  - Release produces no pulse.
- Out, registered, updated on the same edge as Pressed/PressEdge:
  - LEVEL: Out = Pressed (next-state).
  - TOGGLE: rise inverts Out; else Clear forces 0; else hold. Rise and Clear in the same cycle → invert (rise wins).
  - PULSE: Out = rise (identical to PressEdge); Clear ignored.
  - LATCH: rise sets Out = 1; Clear forces 0; Out holds across release. Rise and Clear in the same cycle → 1 (set wins). This is the halt-style behaviour: press halts, release keeps halted until cleared.
- Mode is sampled every cycle; no stored mode.
  - Switching to LEVEL or PULSE immediately drives Out from the new rule on the next edge.
  - Switching to TOGGLE or LATCH keeps the current Out until the next rise or Clear.
- Channels are fully independent; simultaneous events on several channels are processed in the same cycle with no interaction.

Decomposition:
- Shared package button_ctrl_pkg holds:
  - mode constants MODE_LEVEL=2'd0, MODE_TOGGLE=2'd1, MODE_PULSE=2'd2, MODE_LATCH=2'd3;
  - a 2-bit mode typedef.
- One sub-module, button_channel: synchroniser, debounce counter, edge detect and mode output for a single channel.
- Top level generates N_CH instances and slices the Mode, Clear and output buses.

Test Plan (DEBOUNCE_CYCLES=4, N_CH=3, ACTIVE_LOW=1):
- Reset: hold Reset=0 with ButtonIn=3'b000 → Pressed, PressEdge and Out all 0; release reset and keep ButtonIn=0 → Pressed rises exactly 6 edges later, PressEdge=1 for that single cycle.
- Bounce rejection: ch0 ButtonIn toggles 0/1 every 2 cycles for 20 cycles, then settles at 1 → Pressed[0] never goes to 1; counter activity ends with Pressed[0]=0.
- TOGGLE (ch1, Mode=1): two clean presses separated by releases of 10 cycles → Out[1] goes 0→1 on the first accepted press and 1→0 on the second; Clear asserted in the rise cycle → Out[1] still inverts.
- LATCH (ch2, Mode=3): press then release → Out[2]=1 held through release; Clear pulse → Out[2]=0 on the next edge; Clear held high while a press is accepted → Out[2]=1.
- PULSE vs LEVEL (ch0): Mode=2 with a 20-cycle press → Out[0] high for exactly 1 cycle; Mode=0 with the same press → Out[0] tracks Pressed[0] for its full duration, ending 6 edges after raw release.
- Async reset mid-operation: Reset=0 asserted while ch2 is latched and ch1 is partway through debouncing → all outputs clear immediately, before the next clock edge; after reset release, a full 6-edge debounce is required again.

Source files
------------

// File: rtl/button_ctrl_pkg.sv
// Shared mode encoding for the button controller channels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package button_ctrl_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_LEVEL  = 2'd0;
  localparam mode_t MODE_TOGGLE = 2'd1;
  localparam mode_t MODE_PULSE  = 2'd2;
  localparam mode_t MODE_LATCH  = 2'd3;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce filter, press-edge detect, mode output.
// Latency: raw change to o_pressed/o_out = 2 + DEBOUNCE_CYCLES clock edges.
// Backpressure: none; outputs are free-running registered levels/pulses.
module button_channel
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_button,
  input  mode_t i_mode,
  input  logic  i_clear,
  output logic  o_pressed,
  output logic  o_press_edge,
  output logic  o_out
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw level seen while the button is not pressed.
  localparam logic             RELEASED = ACTIVE_LOW;

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pressed;
  logic             r_press_edge;
  logic             r_out;

  logic             w_p;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pressed_nxt;
  logic             w_rise;
  logic             w_out_nxt;

  // Polarity-normalised synchronised level: 1 means pressed.
  assign w_p = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // Two-flop synchroniser; resets to the released level so reset never looks like a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= RELEASED;
      r_sync2 <= RELEASED;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: count consecutive disagreeing samples; accept on the DEBOUNCE_CYCLES-th one.
  always_comb begin
    w_cnt_nxt     = '0;
    w_pressed_nxt = r_pressed;
    if (w_p != r_pressed) begin
      if (r_cnt == CNT_LAST) begin
        w_pressed_nxt = w_p;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  assign w_rise = w_pressed_nxt & ~r_pressed;

  // Mode-dependent next output; mode is live, so TOGGLE/LATCH just keep whatever Out holds.
  always_comb begin
    w_out_nxt = r_out;
    unique case (i_mode)
      MODE_LEVEL:  w_out_nxt = w_pressed_nxt;
      MODE_TOGGLE: begin
        if (w_rise) begin
          w_out_nxt = ~r_out;
        end else if (i_clear) begin
          w_out_nxt = 1'b0;
        end
      end
      MODE_PULSE:  w_out_nxt = w_rise;
      MODE_LATCH:  begin
        if (w_rise) begin
          w_out_nxt = 1'b1;
        end else if (i_clear) begin
          w_out_nxt = 1'b0;
        end
      end
      default:     w_out_nxt = r_out;
    endcase
  end

  // Debounce, edge and output state; async reset drops every partial count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_pressed    <= 1'b0;
      r_press_edge <= 1'b0;
      r_out        <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_pressed    <= w_pressed_nxt;
      r_press_edge <= w_rise;
      r_out        <= w_out_nxt;
    end
  end

  assign o_pressed    = r_pressed;
  assign o_press_edge = r_press_edge;
  assign o_out        = r_out;

endmodule

// File: rtl/button_ctrl.sv
// Multi-channel push-button front end: N_CH independent debounced channels with per-channel mode.
// Latency: raw change to outputs = 2 + DEBOUNCE_CYCLES clock edges per channel.
// Backpressure: none; channels never interact.
module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_CH-1:0]   i_button,
  input  logic [2*N_CH-1:0] i_mode,
  input  logic [N_CH-1:0]   i_clear,
  output logic [N_CH-1:0]   o_pressed,
  output logic [N_CH-1:0]   o_press_edge,
  output logic [N_CH-1:0]   o_out
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_button    (i_button[gi]),
      .i_mode      (i_mode[2*gi +: 2]),
      .i_clear     (i_clear[gi]),
      .o_pressed   (o_pressed[gi]),
      .o_press_edge(o_press_edge[gi]),
      .o_out       (o_out[gi])
    );
  end

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl: sliding-window reference model plus directed literal checks.
module tb_button_ctrl;

  localparam int N_CH = 3;
  localparam int DEB  = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [N_CH-1:0]   button;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   clear;
  logic [N_CH-1:0]   pressed, press_edge, out;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  button_ctrl #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_button(button), .i_mode(mode), .i_clear(clear),
    .o_pressed(pressed), .o_press_edge(press_edge), .o_out(out)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: raw is seen two edges late; Pressed flips once the last DEB
  // normalised samples all disagree with it.
  logic [N_CH-1:0] m_d1, m_d2, m_pressed, m_edge, m_out;
  logic [DEB-1:0]  m_win [N_CH];

  always @(posedge clk or negedge rst_n) begin : model
    logic p, np, rise;
    logic [1:0] md;
    if (!rst_n) begin
      m_d1 = '1; m_d2 = '1; m_pressed = '0; m_edge = '0; m_out = '0;
      for (int c = 0; c < N_CH; c++) m_win[c] = '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        p  = ~m_d2[c];
        m_win[c] = {m_win[c][DEB-2:0], p};
        np = (m_win[c] == {DEB{~m_pressed[c]}}) ? ~m_pressed[c] : m_pressed[c];
        rise = np & ~m_pressed[c];
        md = mode[2*c +: 2];
        case (md)
          2'd0: m_out[c] = np;
          2'd1: m_out[c] = rise ? ~m_out[c] : (clear[c] ? 1'b0 : m_out[c]);
          2'd2: m_out[c] = rise;
          default: m_out[c] = rise ? 1'b1 : (clear[c] ? 1'b0 : m_out[c]);
        endcase
        m_edge[c]    = rise;
        m_pressed[c] = np;
      end
      m_d2 = m_d1;
      m_d1 = button;
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pressed", 32'(pressed), 32'(m_pressed));
      chk("model_press_edge", 32'(press_edge), 32'(m_edge));
      chk("model_out", 32'(out), 32'(m_out));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Edges until (pressed & mask) reaches the wanted level; -1 when the budget runs out.
  task automatic wait_edges(input logic [N_CH-1:0] mask, input logic want, output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if ((pressed & mask) == (want ? mask : '0)) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int hi;
  logic mx;
  int sh [N_CH];

  initial begin
    button = '0; mode = '0; clear = '0;
    #1 rst_n = 1'b0;
    cyc(3);
    cmp_en = 1'b1;
    #1;
    chk("reset_pressed", 32'(pressed), 0);
    chk("reset_press_edge", 32'(press_edge), 0);
    chk("reset_out", 32'(out), 0);

    // Buttons held pressed through reset: acceptance needs the full latency after release.
    @(negedge clk); rst_n = 1'b1;
    wait_edges(3'b111, 1'b1, n);
    chk("reset_release_latency", n, 6);
    chk("reset_release_edge", 32'(press_edge), 32'h7);
    @(posedge clk); #1;
    chk("edge_single_cycle", 32'(press_edge), 0);

    @(negedge clk); button = '1;
    cyc(10);
    chk("all_released", 32'(pressed), 0);

    // Bounce on ch0: each level held 2 cycles.
    mx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) button[0] = ~button[0];
      @(negedge clk); mx |= pressed[0];
    end
    button[0] = 1'b1;
    repeat (10) begin @(negedge clk); mx |= pressed[0]; end
    chk("bounce_reject", 32'(mx), 0);

    // TOGGLE on ch1.
    mode = 6'b00_01_00;
    button[1] = 1'b0; cyc(10);
    chk("toggle_first", 32'(out[1]), 1);
    button[1] = 1'b1; cyc(10);
    chk("toggle_hold_release", 32'(out[1]), 1);
    button[1] = 1'b0; cyc(10);
    chk("toggle_second", 32'(out[1]), 0);
    button[1] = 1'b1; cyc(10);
    button[1] = 1'b0; cyc(5);
    clear[1] = 1'b1; cyc(1);
    clear[1] = 1'b0;
    chk("toggle_rise_beats_clear", 32'(out[1]), 1);
    chk("toggle_rise_cycle", 32'(press_edge[1]), 1);
    button[1] = 1'b1; cyc(10);

    // LATCH on ch2.
    mode = 6'b11_01_00;
    button[2] = 1'b0; cyc(8);
    button[2] = 1'b1; cyc(10);
    chk("latch_hold_release", 32'(out[2]), 1);
    clear[2] = 1'b1; cyc(1);
    clear[2] = 1'b0;
    chk("latch_clear", 32'(out[2]), 0);
    clear[2] = 1'b1; button[2] = 1'b0; cyc(6);
    chk("latch_set_beats_clear", 32'(out[2]), 1);
    clear[2] = 1'b0; button[2] = 1'b1; cyc(10);
    chk("latch_still_set", 32'(out[2]), 1);

    // PULSE then LEVEL on ch0.
    mode = 6'b11_01_10;
    hi = 0;
    button[0] = 1'b0;
    repeat (20) begin @(negedge clk); hi += int'(out[0]); end
    button[0] = 1'b1;
    repeat (10) begin @(negedge clk); hi += int'(out[0]); end
    chk("pulse_width", hi, 1);
    mode = 6'b11_01_00;
    button[0] = 1'b0; cyc(20);
    chk("level_tracks", 32'(out[0]), 1);
    button[0] = 1'b1;
    wait_edges(3'b001, 1'b0, n);
    chk("level_release_latency", n, 6);
    chk("level_out_drop", 32'(out[0]), 0);

    // Async reset with ch2 latched and ch1 mid-debounce.
    @(negedge clk);
    button[1] = 1'b0; cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pressed", 32'(pressed), 0);
    chk("async_press_edge", 32'(press_edge), 0);
    chk("async_out", 32'(out), 0);
    @(negedge clk); rst_n = 1'b1;
    wait_edges(3'b010, 1'b1, n);
    chk("post_reset_latency", n, 6);
    @(negedge clk); button[1] = 1'b1; cyc(10);

    // Randomised traffic with varying bounce rates, clears and live mode changes.
    for (int blk = 0; blk < 40; blk++) begin
      for (int c = 0; c < N_CH; c++) sh[c] = $urandom_range(1, 5);
      if (blk == 20) begin
        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
      for (int i = 0; i < 40; i++) begin
        for (int c = 0; c < N_CH; c++)
          if ($urandom_range(0, (1 << sh[c]) - 1) == 0) button[c] = ~button[c];
        clear = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
        if ($urandom_range(0, 15) == 0) mode = (2*N_CH)'($urandom);
        @(negedge clk);
      end
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
